// File: rtl/alu_execute_unit_if.sv
// ---------------------------------------------------------------------------
// alu_execute_unit_if
// Request/response bundle between the register bank and the execute stage.
//
// Handshake: Start is a request that is accepted on a rising Clock
// only while Busy=0. Once Busy=1, Start is ignored and nothing is queued.
// Done is a one-cycle valid for Result/Result_Dest/Write_Enable/Flags.
// The response side has no backpressure.
//
// Signals
//   Start, Opcode, Source1, Source2, Destination : request (master -> slave)
//   Busy, Done, Write_Enable, Result, Result_Dest, Flags : response
// Modports
//   master : register bank / driver side
//   slave  : execute unit side
// ---------------------------------------------------------------------------
interface alu_execute_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
);
   logic                  Start;
   logic [3:0]            Opcode;
   logic [DATA_WIDTH-1:0] Source1;
   logic [DATA_WIDTH-1:0] Source2;
   logic [ADDR_WIDTH-1:0] Destination;
   logic                  Busy;
   logic                  Done;
   logic                  Write_Enable;
   logic [DATA_WIDTH-1:0] Result;
   logic [ADDR_WIDTH-1:0] Result_Dest;
   logic [3:0]            Flags;

   modport master (
      output Start, Opcode, Source1, Source2, Destination,
      input  Busy, Done, Write_Enable, Result, Result_Dest, Flags
   );

   modport slave (
      input  Start, Opcode, Source1, Source2, Destination,
      output Busy, Done, Write_Enable, Result, Result_Dest, Flags
   );
endinterface

// File: rtl/alu_execute_unit.sv
// ---------------------------------------------------------------------------
// alu_execute_unit
// Execute stage that sits after the register bank. It takes Source1/Source2,
// runs one ALU operation or an iterative shift-add MUL, and returns a
// registered Result, Result_Dest and Write_Enable to the bank write path.
// It also holds the NZCV flags.
//
// Ports
//   Clock     : rising-edge clock
//   Reset_n   : asynchronous active-low reset
//   bus       : alu_execute_unit_if.slave (request/response bundle)
//   dbg_state : current FSM state (0 IDLE, 1 MULT, 2 FINISH)
// ---------------------------------------------------------------------------
module alu_execute_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                    Clock,
   input  logic                    Reset_n,
   alu_execute_unit_if.slave       bus,
   output logic [1:0]              dbg_state
);

   localparam int MSB = DATA_WIDTH - 1;
   localparam int SHW = $clog2(DATA_WIDTH);
   localparam int CW  = $clog2(DATA_WIDTH);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_ORR = 4'b0001;
   localparam logic [3:0] OP_EOR = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_CMP = 4'b0101;
   localparam logic [3:0] OP_MOV = 4'b0110;
   localparam logic [3:0] OP_MVN = 4'b0111;
   localparam logic [3:0] OP_LSL = 4'b1000;
   localparam logic [3:0] OP_LSR = 4'b1001;
   localparam logic [3:0] OP_MUL = 4'b1010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MULT   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t                state;
   logic                  busy_r;
   logic                  done_r;
   logic                  we_r;
   logic [DATA_WIDTH-1:0] result_r;
   logic [ADDR_WIDTH-1:0] dest_r;
   logic [3:0]            flags_r;

   // Multiply datapath
   logic [DATA_WIDTH-1:0] mcand;
   logic [DATA_WIDTH-1:0] mplier;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] acc_next;
   logic [CW-1:0]         cnt;
   logic [ADDR_WIDTH-1:0] mul_dest;

   // Single-cycle ALU results
   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH:0]   diff;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_we;
   logic [3:0]            alu_flags;

   assign bus.Busy         = busy_r;
   assign bus.Done         = done_r;
   assign bus.Write_Enable = we_r;
   assign bus.Result       = result_r;
   assign bus.Result_Dest  = dest_r;
   assign bus.Flags        = flags_r;
   assign dbg_state        = state;

   // The extra top bit of diff is the borrow, so C = ~diff[DATA_WIDTH].
   assign sum  = {1'b0, bus.Source1} + {1'b0, bus.Source2};
   assign diff = {1'b0, bus.Source1} - {1'b0, bus.Source2};

   always_comb begin
      alu_result = '0;
      alu_we     = 1'b1;
      alu_flags  = flags_r;
      case (bus.Opcode)
         OP_AND: alu_result = bus.Source1 & bus.Source2;
         OP_ORR: alu_result = bus.Source1 | bus.Source2;
         OP_EOR: alu_result = bus.Source1 ^ bus.Source2;
         OP_ADD: begin
            alu_result   = sum[MSB:0];
            alu_flags[1] = sum[DATA_WIDTH];
            alu_flags[0] = (bus.Source1[MSB] == bus.Source2[MSB]) &&
                           (sum[MSB] != bus.Source1[MSB]);
         end
         OP_SUB, OP_CMP: begin
            alu_result   = diff[MSB:0];
            alu_we       = (bus.Opcode == OP_SUB);
            alu_flags[1] = ~diff[DATA_WIDTH];
            alu_flags[0] = (bus.Source1[MSB] != bus.Source2[MSB]) &&
                           (diff[MSB] != bus.Source1[MSB]);
         end
         OP_MOV: alu_result = bus.Source2;
         OP_MVN: alu_result = ~bus.Source2;
         OP_LSL: alu_result = bus.Source1 << bus.Source2[SHW-1:0];
         OP_LSR: alu_result = bus.Source1 >> bus.Source2[SHW-1:0];
         default: alu_we = 1'b0;  // undefined: zero result, flags untouched
      endcase
      // N and Z follow the result for every defined single-cycle op.
      if (bus.Opcode <= OP_LSR) begin
         alu_flags[3] = alu_result[MSB];
         alu_flags[2] = (alu_result == '0);
      end
   end

   // Add the shifted multiplicand whenever the current multiplier bit is set.
   assign acc_next = mplier[0] ? (acc + mcand) : acc;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= IDLE;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         we_r     <= 1'b0;
         result_r <= '0;
         dest_r   <= '0;
         flags_r  <= 4'b0000;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
         mul_dest <= '0;
      end else begin
         case (state)
            IDLE, FINISH: begin
               state  <= IDLE;
               done_r <= 1'b0;
               we_r   <= 1'b0;
               if (bus.Start) begin
                  if (bus.Opcode == OP_MUL) begin
                     state    <= MULT;
                     busy_r   <= 1'b1;
                     mcand    <= bus.Source1;
                     mplier   <= bus.Source2;
                     acc      <= '0;
                     cnt      <= '0;
                     mul_dest <= bus.Destination;
                  end else begin
                     state    <= FINISH;
                     done_r   <= 1'b1;
                     we_r     <= alu_we;
                     result_r <= alu_result;
                     dest_r   <= bus.Destination;
                     flags_r  <= alu_flags;
                  end
               end
            end
            MULT: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(DATA_WIDTH - 1)) begin
                  state      <= FINISH;
                  busy_r     <= 1'b0;
                  done_r     <= 1'b1;
                  we_r       <= 1'b1;
                  result_r   <= acc_next;
                  dest_r     <= mul_dest;
                  flags_r[3] <= acc_next[MSB];
                  flags_r[2] <= (acc_next == '0);
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
               we_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_execute_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_execute_unit
// Bench for alu_execute_unit. A driver issues ops, a reference model pushes
// the expected response, and a monitor compares on every Done.
// Packed expectation: {result[31:0], dest[3:0], we, flags[3:0]}.
// ---------------------------------------------------------------------------
module tb_alu_execute_unit;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int EXP_W = DW + AW + 1 + 4;

   logic Clock;
   logic Reset_n;
   logic [1:0] dbg_state;

   alu_execute_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   alu_execute_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not end (errors=%0d)", errors);
      $fatal(1, "timeout");
   end

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   logic [3:0]       model_flags;
   int               checks;
   int               errors;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Computes the expected response from the opcode's arithmetic meaning and
   // advances the model flags.
   function automatic logic [EXP_W-1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b, input logic [AW-1:0] dest);
      logic [DW-1:0] r;
      logic          we;
      logic          defined;
      logic          upd_cv;
      logic          c;
      logic          v;
      longint        s;
      logic [63:0]   prod;
      int            sh;
      r = '0; we = 1'b1; defined = 1'b1; upd_cv = 1'b0; c = 1'b0; v = 1'b0;
      sh = int'(b % 32);
      case (op)
         4'd0: r = a & b;
         4'd1: r = a | b;
         4'd2: r = a ^ b;
         4'd3: begin
            r = a + b;
            upd_cv = 1'b1;
            c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
            s = longint'($signed(a)) + longint'($signed(b));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd4, 4'd5: begin
            r = a - b;
            we = (op == 4'd4);
            upd_cv = 1'b1;
            c = (a >= b);
            s = longint'($signed(a)) - longint'($signed(b));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd6: r = b;
         4'd7: r = ~b;
         4'd8: r = a << sh;
         4'd9: r = a >> sh;
         4'd10: begin
            prod = 64'(a) * 64'(b);
            r = prod[DW-1:0];
         end
         default: begin
            r = '0;
            we = 1'b0;
            defined = 1'b0;
         end
      endcase
      if (defined) begin
         model_flags[3] = r[DW-1];
         model_flags[2] = (r == '0);
         if (upd_cv) begin
            model_flags[1] = c;
            model_flags[0] = v;
         end
      end
      return {r, dest, we, model_flags};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge Clock) begin
      if (Reset_n && bus.Done) begin
         logic [EXP_W-1:0] e;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got Done=1 expected no pending op (t=%0t)", $time);
         end else begin
            e = exp_q.pop_front();
            check("result", 64'(bus.Result), 64'(e[EXP_W-1 -: DW]));
            check("result_dest", 64'(bus.Result_Dest), 64'(e[8:5]));
            check("write_enable", 64'(bus.Write_Enable), 64'(e[4]));
            check("flags", 64'(bus.Flags), 64'(e[3:0]));
            check("busy_in_done", 64'(bus.Busy), 64'd0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge when the DUT is not busy. Returns at the negedge
   // after the op completes, so consecutive calls run back-to-back.
   task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [AW-1:0] dest, input bit poke_during_busy);
      int cnt;
      int busy_cnt;
      exp_q.push_back(model(op, a, b, dest));
      bus.Start       = 1'b1;
      bus.Opcode      = op;
      bus.Source1     = a;
      bus.Source2     = b;
      bus.Destination = dest;
      @(negedge Clock);
      bus.Start = 1'b0;
      if (op == 4'd10) begin
         cnt = 1;
         busy_cnt = 0;
         while (!bus.Done && cnt < 40) begin
            if (bus.Busy) busy_cnt++;
            if (poke_during_busy && cnt < 30) begin
               // Requests during Busy must be ignored and inputs must not
               // disturb the latched operands.
               bus.Start       = 1'($urandom_range(0, 1));
               bus.Opcode      = 4'($urandom_range(0, 15));
               bus.Source1     = $urandom;
               bus.Source2     = $urandom;
               bus.Destination = 4'($urandom_range(0, 15));
            end else begin
               bus.Start = 1'b0;
            end
            @(negedge Clock);
            cnt++;
         end
         bus.Start = 1'b0;
         check("mul_latency", 64'(cnt), 64'd33);
         check("mul_busy_cycles", 64'(busy_cnt), 64'd32);
      end
   endtask

   task automatic idle_cycles(input int n);
      bus.Start = 1'b0;
      repeat (n) @(negedge Clock);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 64'(bus.Busy), 64'd0);
      check({tag, "_done"}, 64'(bus.Done), 64'd0);
      check({tag, "_we"}, 64'(bus.Write_Enable), 64'd0);
      check({tag, "_result"}, 64'(bus.Result), 64'd0);
      check({tag, "_dest"}, 64'(bus.Result_Dest), 64'd0);
      check({tag, "_flags"}, 64'(bus.Flags), 64'd0);
      check({tag, "_state"}, 64'(dbg_state), 64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [3:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      checks = 0;
      errors = 0;
      model_flags = 4'b0000;
      bus.Start = 1'b0;
      bus.Opcode = 4'd0;
      bus.Source1 = '0;
      bus.Source2 = '0;
      bus.Destination = '0;
      Reset_n = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (3) @(negedge Clock);
      Reset_n = 1'b1;
      @(negedge Clock);

      // Directed cases
      issue(4'd3, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3, 1'b0);   // ADD overflow
      issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 4'd7, 1'b0);  // undefined
      idle_cycles(2);
      issue(4'd5, 32'd5, 32'd5, 4'd1, 1'b0);                   // CMP equal
      issue(4'd4, 32'd3, 32'd5, 4'd2, 1'b0);                   // SUB negative
      issue(4'd10, 32'h0001_0003, 32'h0002_0005, 4'd9, 1'b1);  // MUL
      issue(4'd8, 32'h0000_0001, 32'h0000_0021, 4'd4, 1'b0);   // LSL by 33
      issue(4'd9, 32'h8000_0000, 32'd31, 4'd5, 1'b0);          // LSR by 31
      issue(4'd8, 32'hDEAD_BEEF, 32'h0000_0020, 4'd6, 1'b0);   // shift by 0
      issue(4'd9, 32'hCAFE_F00D, 32'd0, 4'd6, 1'b0);
      issue(4'd6, 32'h0, 32'h0, 4'd8, 1'b0);                   // MOV zero
      issue(4'd7, 32'h0, 32'h0, 4'd8, 1'b0);                   // MVN
      issue(4'd3, 32'hFFFF_FFFF, 32'h1, 4'd10, 1'b0);          // ADD carry, zero
      idle_cycles(3);

      // Reset in the middle of a MUL: everything clears, no write-back later
      bus.Start = 1'b1;
      bus.Opcode = 4'd10;
      bus.Source1 = 32'h1234_5678;
      bus.Source2 = 32'h0000_0FFF;
      bus.Destination = 4'd12;
      @(negedge Clock);
      bus.Start = 1'b0;
      repeat (9) @(negedge Clock);
      #2 Reset_n = 1'b0;
      #1;
      check_all_zero("mid_mul_reset");
      model_flags = 4'b0000;
      repeat (2) @(negedge Clock);
      Reset_n = 1'b1;
      repeat (40) @(negedge Clock);
      check("post_reset_busy", 64'(bus.Busy), 64'd0);
      check("post_reset_done", 64'(bus.Done), 64'd0);
      check("post_reset_result", 64'(bus.Result), 64'd0);

      // Randomized ops, mixed with idle gaps and back-to-back issue
      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 5))
            0: a = 32'h8000_0000;
            1: a = 32'h7FFF_FFFF;
            2: a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: b = a;
            2: b = 32'($urandom_range(0, 40));
            default: b = $urandom;
         endcase
         issue(op, a, b, 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      end

      idle_cycles(5);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
